// File: rtl/reset_sequencer_pkg.sv
// Shared types and elaboration-time helpers for the multi-domain reset sequencer.
`timescale 1ns/1ps
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
    WAIT_READY,
    GAP,
    DONE,
    SHUTDOWN
  } seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // True when every sequencer parameter is within its legal range.
  function automatic bit params_legal(input int n_domains, input int sync_stages,
                                      input int hold_cycles, input int stage_gap,
                                      input int timeout_cycles);
    return (n_domains >= 1) && (sync_stages >= 2) && (hold_cycles >= 1) &&
           (stage_gap >= 1) && (timeout_cycles >= 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Per-domain reset/ready bundle between the sequencer (master) and the domains it controls (slave).
`timescale 1ns/1ps
interface reset_sequencer_if #(
  parameter int N_DOMAINS = 3
);
  logic [N_DOMAINS-1:0] domain_ready;
  logic                 sw_reset_req;
  logic [N_DOMAINS-1:0] rst_out;
  logic                 seq_done;
  logic                 timeout_err;

  modport master (
    input  domain_ready,
    input  sw_reset_req,
    output rst_out,
    output seq_done,
    output timeout_err
  );

  modport slave (
    output domain_ready,
    output sw_reset_req,
    input  rst_out,
    input  seq_done,
    input  timeout_err
  );
endinterface

// File: rtl/reset_sync_chain.sv
// Reset synchronizer: asserts asynchronously, deasserts STAGES clock edges after reset_async falls.
`timescale 1ns/1ps
module reset_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_async,
  output logic rst_sync
);

  if (STAGES < 2) begin : g_bad_stages
    $error("reset_sync_chain: STAGES must be at least 2");
  end

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_DOMAINS resets in ascending order after a synchronized system reset,
// waiting on each domain's ready (with timeout) plus a fixed gap; supports orderly shutdown.
`timescale 1ns/1ps
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS      = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int STAGE_GAP      = 2,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset_async,
  reset_sequencer_if.master bus
);

  localparam int CNT_MAX = max3(HOLD_CYCLES, STAGE_GAP, TIMEOUT_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DOMAINS - 1);

  if (!params_legal(N_DOMAINS, SYNC_STAGES, HOLD_CYCLES, STAGE_GAP, TIMEOUT_CYCLES)) begin : g_bad_params
    $error("reset_sequencer: illegal parameter set");
  end

  logic                 rst_sync;
  seq_state_t           state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_dn;
  logic [N_DOMAINS-1:0] rst_out_q;
  logic                 seq_done_q;
  logic                 timeout_err_q;

  reset_sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset_async(reset_async),
    .rst_sync   (rst_sync)
  );

  assign idx_dn = idx - 1'b1;

  // Counter is cleared on every state change, so each state counts its own edges from 0.
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      state         <= HOLD;
      cnt           <= '0;
      idx           <= '0;
      rst_out_q     <= '1;
      seq_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (rst_sync) begin
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RELEASE: begin
          rst_out_q[idx] <= 1'b0;
          cnt            <= '0;
          state          <= WAIT_READY;
        end

        WAIT_READY: begin
          if (bus.domain_ready[idx] || (cnt == TMO_LAST)) begin
            if (!bus.domain_ready[idx]) begin
              timeout_err_q <= 1'b1;
            end
            cnt <= '0;
            if (idx == IDX_LAST) begin
              seq_done_q <= 1'b1;
              state      <= DONE;
            end else begin
              state <= GAP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            idx   <= idx + 1'b1;
            state <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A single-domain design has nothing left to walk down, so it skips SHUTDOWN.
        DONE: begin
          if (bus.sw_reset_req) begin
            rst_out_q[IDX_LAST] <= 1'b1;
            seq_done_q          <= 1'b0;
            timeout_err_q       <= 1'b0;
            idx                 <= IDX_LAST;
            cnt                 <= '0;
            state               <= (N_DOMAINS == 1) ? HOLD : SHUTDOWN;
          end
        end

        SHUTDOWN: begin
          if (cnt == GAP_LAST) begin
            cnt               <= '0;
            idx               <= idx_dn;
            rst_out_q[idx_dn] <= 1'b1;
            if (idx_dn == '0) begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          cnt   <= '0;
          state <= HOLD;
        end
      endcase
    end
  end

  assign bus.rst_out     = rst_out_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: a timing-rule model queues expected output changes; a monitor pops them as the DUT changes.
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int SYNC = 2;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int TMO  = 8;
  localparam int W    = N + 2;
  localparam logic [W-1:0] RESET_OUTS = {{N{1'b1}}, 2'b00};

  logic clk         = 1'b0;
  logic reset_async = 1'b0;

  reset_sequencer_if #(.N_DOMAINS(N)) bus ();

  reset_sequencer #(
    .N_DOMAINS     (N),
    .SYNC_STAGES   (SYNC),
    .HOLD_CYCLES   (HOLD),
    .STAGE_GAP     (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset_async(reset_async),
    .bus        (bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    int             edge_no;
    logic [W-1:0]   outs;
  } exp_evt_t;

  exp_evt_t       exp_q[$];
  int             checks = 0;
  int             errors = 0;
  int             total_edges = 0;
  int             fall_edge = 0;
  int             k_delay [N];
  bit             late_drop [N];
  int             dom_cnt [N];
  logic [N-1:0]   exp_rst;
  logic           exp_done;
  logic           exp_terr;
  logic [W-1:0]   last_pushed;

  always @(posedge clk) total_edges++;

  // Each domain raises ready k_delay edges after its reset drops; some drop it again later.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.rst_out[i] !== 1'b0) begin
        dom_cnt[i] = 0;
        bus.domain_ready[i] = 1'b0;
      end else begin
        dom_cnt[i]++;
        bus.domain_ready[i] = (dom_cnt[i] >= k_delay[i]) &&
                              !(late_drop[i] && (dom_cnt[i] >= k_delay[i] + 3));
      end
    end
  end

  task automatic checkOutput(input string name, input int act_edge, input logic [W-1:0] act,
                             input int exp_edge, input logic [W-1:0] expv);
    checks++;
    if ((act !== expv) || (act_edge != exp_edge)) begin
      errors++;
      $display("[TB] FAIL %s: got {rst_out,seq_done,timeout_err}=%b at edge %0d, expected %b at edge %0d",
               name, act, act_edge, expv, exp_edge);
    end
  endtask

  task automatic expect_at(input int e);
    exp_evt_t     ev;
    logic [W-1:0] cur;
    cur = {exp_rst, exp_done, exp_terr};
    if ((exp_q.size() > 0) && (exp_q[$].edge_no == e)) begin
      ev = exp_q.pop_back();
      ev.outs = cur;
      exp_q.push_back(ev);
    end else if (cur != last_pushed) begin
      ev.edge_no = e;
      ev.outs    = cur;
      exp_q.push_back(ev);
    end
    last_pushed = cur;
  endtask

  // Domain i released at t; its decision comes min(k,TMO) edges later; next release GAP+1 after that.
  task automatic model_bringup(input int t0, output int d_edge);
    int t;
    t = t0;
    d_edge = t0;
    for (int i = 0; i < N; i++) begin
      exp_rst[i] = 1'b0;
      expect_at(t);
      if (k_delay[i] <= TMO) begin
        d_edge = t + k_delay[i];
      end else begin
        d_edge = t + TMO;
        exp_terr = 1'b1;
        expect_at(d_edge);
      end
      if (i == N - 1) begin
        exp_done = 1'b1;
        expect_at(d_edge);
      end else begin
        t = d_edge + GAP + 1;
      end
    end
  endtask

  task automatic model_shutdown(input int s_edge, output int d_edge);
    exp_rst[N-1] = 1'b1;
    exp_done     = 1'b0;
    exp_terr     = 1'b0;
    expect_at(s_edge);
    for (int j = N - 2; j >= 0; j--) begin
      exp_rst[j] = 1'b1;
      expect_at(s_edge + (N - 1 - j) * GAP);
    end
    model_bringup(s_edge + (N - 1) * GAP + HOLD + 1, d_edge);
  endtask

  task automatic set_k(input int k0, input int k1, input int k2);
    k_delay[0] = k0;
    k_delay[1] = k1;
    k_delay[2] = k2;
    for (int i = 0; i < N; i++) late_drop[i] = 1'b0;
  endtask

  // Called at a negedge; the reset edge lands 3 ns later and falls before the next posedge.
  task automatic applyReset(input int extra_cycles, input int width_ns);
    #3;
    reset_async = 1'b1;
    #(20 * extra_cycles + width_ns);
    reset_async = 1'b0;
    fall_edge = total_edges;
    #1;
  endtask

  task automatic applyStimulus(input int abort_at, input bit do_shutdown, input bit rand_k,
                               input int ign_req, input int extra_cycles, input int width_ns);
    int d1, d2, s_edge, ign, last_edge, end_edge, n, budget;
    if (rand_k) begin
      for (int i = 0; i < N; i++) begin
        k_delay[i]   = ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(1, 12));
        late_drop[i] = 1'($urandom_range(0, 1));
      end
    end
    applyReset(extra_cycles, width_ns);
    exp_rst     = '1;
    exp_done    = 1'b0;
    exp_terr    = 1'b0;
    last_pushed = RESET_OUTS;
    model_bringup(SYNC + HOLD + 1, d1);
    last_edge = d1;
    s_edge    = -1;
    if (do_shutdown) begin
      s_edge = d1 + int'($urandom_range(1, 4));
      model_shutdown(s_edge, d2);
      last_edge = d2;
    end
    if (ign_req > 0)       ign = ign_req;
    else if (ign_req == 0) ign = int'($urandom_range(2, d1));
    else                   ign = -1;
    end_edge = (abort_at > 0) ? abort_at : last_edge;
    forever begin
      @(negedge clk);
      n = total_edges - fall_edge;
      if (n >= end_edge) break;
      bus.sw_reset_req = ((n + 1) == ign) || ((n + 1) == s_edge);
    end
    bus.sw_reset_req = 1'b0;
    if (abort_at > 0) return;
    budget = 30;
    while ((exp_q.size() > 0) && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expected changes still pending at edge %0d, required 0",
               exp_q.size(), total_edges - fall_edge);
      exp_q.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  // Monitor: checks the asynchronous reset response and every registered output change.
  initial begin
    logic [W-1:0] last_seen;
    logic [W-1:0] cur;
    bit           armed;
    bit           prev_rst;
    exp_evt_t     ev;
    int           rel;
    armed     = 1'b0;
    prev_rst  = 1'b0;
    last_seen = RESET_OUTS;
    forever begin
      @(negedge clk or posedge reset_async);
      rel = total_edges - fall_edge;
      if (reset_async && !prev_rst) begin
        prev_rst = 1'b1;
        armed    = 1'b1;
        while (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          if (ev.edge_no <= rel) begin
            checks++;
            errors++;
            $display("[TB] FAIL missed_change: no output change seen, required %b at edge %0d",
                     ev.outs, ev.edge_no);
          end
        end
        #0.5;
        checkOutput("async_reset", rel, {bus.rst_out, bus.seq_done, bus.timeout_err}, rel, RESET_OUTS);
        last_seen = RESET_OUTS;
      end else if (!reset_async) begin
        prev_rst = 1'b0;
        if (armed) begin
          cur = {bus.rst_out, bus.seq_done, bus.timeout_err};
          if (cur !== last_seen) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_change: got %b at edge %0d, required no change from %b",
                       cur, rel, last_seen);
            end else begin
              ev = exp_q.pop_front();
              checkOutput("output_change", rel, cur, ev.edge_no, ev.outs);
            end
            last_seen = cur;
          end
        end
      end
    end
  end

  initial begin
    bus.sw_reset_req = 1'b0;
    bus.domain_ready = '0;
    set_k(1, 1, 1);
    @(negedge clk);

    $display("[TB] bring-up, all domains ready");
    set_k(1, 1, 1);
    applyStimulus(0, 1'b0, 1'b0, -1, 1, 2);

    $display("[TB] domain 1 never ready");
    set_k(1, 1000, 1);
    applyStimulus(0, 1'b0, 1'b0, -1, 0, 4);

    $display("[TB] reset between edges 12 and 13, then rerun");
    set_k(1, 1, 1);
    applyStimulus(12, 1'b0, 1'b0, -1, 1, 2);
    applyStimulus(0, 1'b0, 1'b0, -1, 0, 3);

    $display("[TB] 1 ns glitch while in DONE");
    applyStimulus(20, 1'b0, 1'b0, -1, 0, 2);
    applyStimulus(0, 1'b0, 1'b0, -1, 0, 1);

    $display("[TB] software shutdown and restart");
    applyStimulus(0, 1'b1, 1'b0, -1, 0, 2);

    $display("[TB] request during WAIT_READY is ignored");
    applyStimulus(0, 1'b0, 1'b0, 8, 0, 2);

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      applyStimulus(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(3, 45)),
                    1'($urandom_range(0, 1)), 1'b1, 0,
                    int'($urandom_range(0, 2)), int'($urandom_range(1, 5)));
    end
    applyStimulus(0, 1'b1, 1'b1, 0, 0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Multi-domain reset sequencer: takes one asynchronous system reset, synchronizes its deassertion, then releases `N_DOMAINS` downstream resets one at a time in ascending order. Before releasing the next domain it waits for the current domain's ready handshake, with a timeout, and then a fixed gap. It also supports a software-requested orderly shutdown and restart. It sits between the board-level reset input and the per-domain reset nets of the design.

## Interface
- `N_DOMAINS`, 3: number of reset domains; must be ≥1.
- `SYNC_STAGES`, 2: synchronizer flops on reset deassertion; must be ≥2.
- `HOLD_CYCLES`, 4: cycles held after the synchronized reset drops, before domain 0 is released; must be ≥1.
- `STAGE_GAP`, 2: gap cycles between domain events; must be ≥1.
- `TIMEOUT_CYCLES`, 8: maximum number of cycles to wait for `domain_ready[i]`; must be ≥1.
- `clk` in 1: the single clock.
- `reset_async` in 1: asynchronous, active-high reset. Assertion acts immediately; deassertion is synchronized internally.
- `domain_ready` in N_DOMAINS: bit i is high when domain i has finished its local init. Treated as level; asynchronous to nothing.
- `sw_reset_req` in 1: single-cycle request for an orderly shutdown and restart.
- `rst_out` out N_DOMAINS: active-high per-domain resets.
- `seq_done` out 1: high when all domains have been released.
- `timeout_err` out 1: sticky flag; set when any ready wait timed out.

## Operation
- **Reset (`reset_async`=1, asynchronous):**
  - `rst_out` goes to all-ones immediately.
  - `seq_done`=0 and `timeout_err`=0.
  - State is HOLD; counter=0; index=0; synchronizer chain is forced to 1.
- **Synchronizer:** `rst_sync` is the output of a `SYNC_STAGES`-deep chain that shifts in 0 each edge. It falls `SYNC_STAGES` edges after `reset_async` falls. Any `reset_async` pulse, even sub-cycle, restarts everything.
- **FSM states:** HOLD, RELEASE, WAIT_READY, GAP, DONE, SHUTDOWN.
  - **HOLD:** the counter stays cleared while `rst_sync`=1. After that it counts edges; at count `HOLD_CYCLES` it moves to RELEASE.
  - **RELEASE:** clears `rst_out[idx]` on this edge, then goes to WAIT_READY with the counter cleared.
  - **WAIT_READY:** each edge, sample `domain_ready[idx]`.
    - If it is 1: go to DONE when idx=N_DOMAINS-1; otherwise go to GAP.
    - If it is still 0 on the `TIMEOUT_CYCLES`-th WAIT_READY edge: set `timeout_err` and take the same transition as above.
  - **GAP:** counts `STAGE_GAP` edges, then idx++ and go to RELEASE.
  - **DONE:** `seq_done`=1 (registered on entry). `sw_reset_req`=1 moves to SHUTDOWN.
  - **SHUTDOWN:**
    - On the entry edge: `rst_out[N_DOMAINS-1]`=1, `seq_done`=0, `timeout_err`=0, idx=N_DOMAINS-1.
    - Then every `STAGE_GAP` edges: idx-- and set `rst_out[idx]`.
    - On the edge that sets `rst_out[0]`: go to HOLD. `rst_sync` is already 0, so the hold count starts on the next edge.
- **Ignored inputs:**
  - `sw_reset_req` is ignored outside DONE.
  - `domain_ready` is ignored outside WAIT_READY.
  - A ready signal that drops after its domain has been released has no effect.
- **Reset mid-operation:** `reset_async` in any state gives the full reset values above. An in-progress SHUTDOWN is abandoned.
- **Widths:**
  - Counter is `$clog2(max(HOLD_CYCLES,STAGE_GAP,TIMEOUT_CYCLES)+1)` bits, never wraps, and is cleared on every state change.
  - idx is `max(1,$clog2(N_DOMAINS))` bits.
- **Single domain (N_DOMAINS=1):** GAP is never entered; SHUTDOWN asserts `rst_out[0]` on entry and goes straight to HOLD.

## Timing
- Edges are counted from the first rising edge after `reset_async` falls, which is edge 1.
- `rst_out[0]` falls on edge `SYNC_STAGES+HOLD_CYCLES+1`.
- With ready already high, consecutive releases are `STAGE_GAP+2` edges apart.
- `seq_done` rises one edge after the last release.
- Each timeout adds `TIMEOUT_CYCLES-1` edges to the spacing.
- Shutdown, with `sw_reset_req` sampled on edge S:
  - `rst_out[N-1]` rises at S.
  - Each lower domain rises `STAGE_GAP` edges after the previous one.
  - `rst_out[0]` is released again at S+(N-1)·STAGE_GAP+HOLD_CYCLES+1.
- All outputs are registered; none are driven combinationally from inputs.

## Structure
- Package `reset_seq_pkg`: the state enum `seq_state_t` and the parameter-legality checks.
- Sub-module `reset_sync_chain`: parameter `STAGES`; asynchronous set from `reset_async`; output `rst_sync`. Reused for any other single-domain reset synchronizing.
- The FSM, counter and index register live in `reset_sequencer`.

## Test plan
All scenarios use the default parameters (N=3, SYNC=2, HOLD=4, GAP=2, TIMEOUT=8) with a 20 ns clock.

- **Basic bring-up:** hold `reset_async` high, drop it, `domain_ready`=3'b111.
  - `rst_out` 111→110 at edge 7, →100 at 11, →000 at 15.
  - `seq_done`=1 at edge 16; `timeout_err`=0.
- **Timeout:** `domain_ready[1]` stuck at 0, other bits 1.
  - `rst_out[1]` falls at edge 11; `timeout_err` is set at edge 19.
  - `rst_out[2]` falls at edge 22; `seq_done` rises at 23.
- **Reset mid-sequence:** `reset_async` pulses high between edges 12 and 13.
  - `rst_out`=111 immediately, `seq_done`=0.
  - The sequence reruns with the same offsets, counted from the new fall.
- **Glitch:** a 1 ns `reset_async` pulse while in DONE.
  - All resets assert asynchronously.
  - Full re-sequence; `rst_out[0]` falls 7 edges later.
- **Software shutdown:** in DONE, pulse `sw_reset_req` at edge S.
  - `rst_out` becomes 100 at S, 110 at S+2, 111 at S+4.
  - `rst_out[0]` is released at S+9; `seq_done` is low from S until the restart completes.
- **Ignored request:** pulse `sw_reset_req` during WAIT_READY.
  - No effect; sequence timing matches the bring-up scenario.
